// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path: the byte width used by both
// the Transmitter and the arbiter, and the arbiter's FSM state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

endpackage

// File: rtl/rr_arbiter_comb.sv
// ---------------------------------------------------------------------------
// rr_arbiter_comb
// Purely combinational round-robin pick: scans last+1, last+2, ... modulo N
// and returns the first requesting index.
//   req_i    : request vector, one bit per requester
//   last_i   : index granted most recently (lowest priority this round)
//   any_o    : at least one request bit is set
//   winner_o : selected index (0 when any_o is low)
// ---------------------------------------------------------------------------
module rr_arbiter_comb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  logic [IW-1:0] cand_s;

  // rotating priority scan; the first hit keeps the grant
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand_s   = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s   = IW'((int'(last_i) + k) % N);
      winner_o = (!any_o && req_i[cand_s]) ? cand_s : winner_o;
      any_o    = any_o | req_i[cand_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART Transmitter between NUM_REQ byte requesters.
// Flow: IDLE picks a requester round-robin and latches its byte, START pulses
// tx_start/req_ready, BUSY waits for tx_done (with a watchdog), GAP holds off
// re-arbitration for GAP_CYCLES cycles (at least one).
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   req_valid, req_data   : per-requester valid bit and byte (8 bits each)
//   req_ready             : one-cycle accept pulse to the granted requester
//   tx_start, tx_in       : start pulse and byte to the Transmitter
//   tx_done               : frame-complete pulse from the Transmitter
//   sent_valid, sent_id   : normal completion pulse and requester index
//   busy                  : high whenever not IDLE
//   err_timeout, err_clear: sticky watchdog flag and its clear
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 1000000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_in,
  input  logic                       tx_done,
  output logic                       sent_valid,
  output logic [$clog2(NUM_REQ)-1:0] sent_id,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clear
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int G_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST  = GW'(G_LAST_I);

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [DATA_W-1:0]  tx_in_q, tx_in_d;
  logic [IDW-1:0]     sent_id_q, sent_id_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_start_q, tx_start_d;
  logic               sent_valid_q, sent_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic               any_s;
  logic [IDW-1:0]     win_s;
  logic               timeout_s;

  rr_arbiter_comb #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr (
    .req_i    (req_valid),
    .last_i   (last_q),
    .any_o    (any_s),
    .winner_o (win_s)
  );

  // next-state and registered-output logic for the arbitration FSM
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    tx_in_d      = tx_in_q;
    sent_id_d    = sent_id_q;
    req_ready_d  = '0;
    tx_start_d   = 1'b0;
    sent_valid_d = 1'b0;
    tcnt_d       = tcnt_q;
    gcnt_d       = gcnt_q;
    timeout_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          tx_in_d            = req_data[int'(win_s)*DATA_W +: DATA_W];
          sent_id_d          = win_s;
          last_d             = win_s;
          req_ready_d[win_s] = 1'b1;
          tx_start_d         = 1'b1;
          tcnt_d             = '0;
          state_d            = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // the watchdog window is measured from the tx_start cycle
        tcnt_d  = TW'(1);
        state_d = BUSY;
      end
      BUSY: begin
        if (tx_done) begin
          sent_valid_d = 1'b1;
          tcnt_d       = '0;
          gcnt_d       = '0;
          state_d      = GAP;
        end else if (tcnt_q >= TO_LAST) begin
          timeout_s = 1'b1;
          tcnt_d    = '0;
          gcnt_d    = '0;
          state_d   = GAP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      GAP: begin
        // a zero-length gap still costs the one registered GAP cycle
        if ((GAP_CYCLES == 0) || (gcnt_q == G_LAST)) begin
          gcnt_d  = '0;
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // a timeout in the same cycle as err_clear keeps the flag set
    if (timeout_s) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    busy_d = (state_d != IDLE);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IDW'(NUM_REQ - 1);
      tx_in_q      <= '0;
      sent_id_q    <= '0;
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      sent_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      tcnt_q       <= '0;
      gcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tx_in_q      <= tx_in_d;
      sent_id_q    <= sent_id_d;
      req_ready_q  <= req_ready_d;
      tx_start_q   <= tx_start_d;
      sent_valid_q <= sent_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      tcnt_q       <= tcnt_d;
      gcnt_q       <= gcnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_in       = tx_in_q;
  assign sent_valid  = sent_valid_q;
  assign sent_id     = sent_id_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
